// File: rtl/fifo_pkg.sv
// Shared constants, op_state encoding and helpers for the FIFO control slice.
package fifo_pkg;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    typedef logic [1:0] op_state_t;

    // Accepted operations of the previous cycle; bit 0 = write, bit 1 = read.
    localparam op_state_t NOP   = 2'b00;
    localparam op_state_t WRITE = 2'b01;
    localparam op_state_t READ  = 2'b10;
    localparam op_state_t RDWR  = 2'b11;

    // One-hot decode of a register index.
    function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer with increment enable; width AW wraps mod 2**AW.
module fifo_ptr #(
    parameter int unsigned AW = 3
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_inc,
    output logic [AW-1:0] o_ptr
);

    logic [AW-1:0] r_ptr;

    // Advance on enable; natural overflow provides the wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control: head/tail pointers, occupancy, register-bank enables and handshake flags.
module fifo_ctrl
    import fifo_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr_en,
    input  logic             i_rd_en,
    output logic [DEPTH-1:0] o_reg_we,
    output logic [AW-1:0]    o_rd_addr,
    output logic             o_dout_le,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_data_count,
    output logic             o_wr_ack,
    output logic             o_wr_err,
    output logic             o_rd_ack,
    output logic             o_rd_err
);

    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [AW:0]   r_count;
    op_state_t     r_op_state;
    logic          r_wr_err;
    logic          r_rd_err;

    logic [AW-1:0] w_head;
    logic [AW-1:0] w_tail;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic [AW:0]   w_count_nxt;
    op_state_t     w_op_state_nxt;

    // Requests are masked while reset is held so no enable leaks to the bank.
    assign w_wr_ok = i_reset_n & i_wr_en & (r_count != COUNT_FULL);
    assign w_rd_ok = i_reset_n & i_rd_en & (r_count != '0);

    fifo_ptr #(
        .AW (AW)
    ) u_head (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_rd_ok),
        .o_ptr     (w_head)
    );

    fifo_ptr #(
        .AW (AW)
    ) u_tail (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_wr_ok),
        .o_ptr     (w_tail)
    );

    // Next occupancy and record of which operations were accepted.
    always_comb begin
        w_count_nxt    = r_count;
        w_op_state_nxt = NOP;
        unique case ({w_rd_ok, w_wr_ok})
            2'b01: begin
                w_count_nxt    = r_count + 1'b1;
                w_op_state_nxt = WRITE;
            end
            2'b10: begin
                w_count_nxt    = r_count - 1'b1;
                w_op_state_nxt = READ;
            end
            2'b11: w_op_state_nxt = RDWR;
            default: w_op_state_nxt = NOP;
        endcase
    end

    // Occupancy, op_state and rejection flags.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count    <= '0;
            r_op_state <= NOP;
            r_wr_err   <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_op_state <= w_op_state_nxt;
            r_wr_err   <= i_wr_en & ~w_wr_ok;
            r_rd_err   <= i_rd_en & ~w_rd_ok;
        end
    end

    assign o_reg_we     = w_wr_ok ? onehot(w_tail) : '0;
    assign o_rd_addr    = w_head;
    assign o_dout_le    = w_rd_ok;
    assign o_full       = (r_count == COUNT_FULL);
    assign o_empty      = (r_count == '0);
    assign o_data_count = r_count;
    assign o_wr_ack     = (r_op_state == WRITE) || (r_op_state == RDWR);
    assign o_rd_ack     = (r_op_state == READ) || (r_op_state == RDWR);
    assign o_wr_err     = r_wr_err;
    assign o_rd_err     = r_rd_err;

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Control and sequencing block for the 8-entry × 32-bit register-file FIFO. It owns the head/tail pointers and the occupancy count, and turns `rd_en`/`wr_en` requests into:
- the one-hot write enables for the eight data registers;
- the read-mux select address;
- the output-register load strobe;
- registered handshake and status flags.

It sits between the FIFO top level and the register bank / 8-to-1 read mux, and carries no data itself.

## Interface
- `DEPTH`, 8, number of data registers; must be a power of two.
- `AW`, 3, pointer width, log2(`DEPTH`).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request for this cycle.
- `rd_en`  in  1  read request for this cycle.
- `reg_we`  out  `DEPTH`  one-hot write enable to the data registers; bit `tail` is asserted on an accepted write.
- `rd_addr`  out  `AW`  read-mux select; always equals `head`.
- `dout_le`  out  1  output-register load; asserted on an accepted read.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `data_count`  out  `AW`+1  current occupancy, 0..8.
- `wr_ack`  out  1  registered: a write was accepted last cycle.
- `wr_err`  out  1  registered: a write was rejected last cycle (FIFO full).
- `rd_ack`  out  1  registered: a read was accepted last cycle.
- `rd_err`  out  1  registered: a read was rejected last cycle (FIFO empty).

## Operation
- **State register** holds `head`, `tail`, `count`, `op_state`, and the four ack/err flags.
- **Accept rules**, evaluated on the current registered `count`:
  - `wr_ok = wr_en & (count != DEPTH)`
  - `rd_ok = rd_en & (count != 0)`
- **Simultaneous read and write** (both requested):
  - Each is accepted or rejected independently.
  - When the FIFO is full: the read is accepted, the write is rejected and `wr_err` is set. There is no same-cycle slot reuse.
  - When the FIFO is empty: the write is accepted, the read is rejected and `rd_err` is set.
- **Pointer updates:**
  - `wr_ok`: `tail <= tail+1`.
  - `rd_ok`: `head <= head+1`.
  - Both pointers wrap mod `DEPTH` (7 → 0).
- **Count update:** `count += wr_ok - rd_ok`, so it is unchanged when both are accepted.
- **`op_state`** is encoded `NOP`, `WRITE`, `READ`, `RDWR` and records the accepted operations of the previous cycle. It drives the ack outputs:
  - `wr_ack` is set in `WRITE` and `RDWR`.
  - `rd_ack` is set in `READ` and `RDWR`.
- **Error flags** are registered from the rejections of the previous cycle; both can be set in the same cycle as acks for the other port.
- **Combinational outputs:**
  - `reg_we = wr_ok ? (1 << tail) : 0`
  - `dout_le = rd_ok`
  - `rd_addr = head`
- **Derived flags:** `full`, `empty`, and `data_count` decode from the registered `count`.
- **Reset** (`reset_n` low, at any time, including mid-operation):
  - `head = tail = count = 0`, `op_state = NOP`, all ack/err flags 0.
  - Therefore `empty = 1`, `full = 0`, `data_count = 0`, `reg_we = 0` (while reset is held), `dout_le = 0`, `rd_addr = 0`.
  - Register contents are not cleared; they become unreachable.

## Timing
- **Write:** `reg_we` is asserted in the request cycle, and the data register captures on that rising edge. `count`, `full`, `empty`, and `wr_ack` (or `wr_err`) update at the same edge and are visible the following cycle.
- **Read:** `rd_addr = head` is stable before the edge, so the read mux output is valid in the request cycle. `dout_le` loads the output register on that edge, giving one-cycle read latency. `rd_ack` (or `rd_err`) is visible in the cycle after the request.
- **Flags are not look-ahead:**
  - A write arriving with `count == 7` is accepted.
  - A second write in the next cycle sees `full = 1` and is rejected.
- **Reset timing:** assertion takes effect immediately without a clock. Deassertion is assumed synchronised externally; the first request is honoured on the first edge after deassertion.

## Structure
- **Shared package `fifo_pkg`:** `DEPTH`, `AW`, and the `op_state` encodings (`NOP=2'b00`, `WRITE=2'b01`, `READ=2'b10`, `RDWR=2'b11`).
- **Sub-module `fifo_ptr`:** an `AW`-bit wrap-around pointer with increment enable and async active-low reset. It is instanced twice, for head and tail.
- **Kept in this block:** count, flags, and one-hot decode.

## Test plan
- **Reset:** drive `reset_n = 0` with requests active → `empty = 1`, `full = 0`, `data_count = 0`, `reg_we = 0`, all ack/err flags 0, `rd_addr = 0`.
- **Fill:** 8 consecutive writes from reset →
  - `reg_we` walks `0x01`, `0x02` … `0x80`;
  - `wr_ack = 1` each following cycle;
  - after the 8th write, `full = 1` and `data_count = 8`.
  - A 9th write → `reg_we = 0`, `wr_err = 1` next cycle, count stays 8.
- **Drain:** 8 reads from full →
  - `rd_addr` steps 0 … 7;
  - `dout_le` is asserted each cycle;
  - `empty = 1` after the 8th read.
  - A 9th read → `dout_le = 0`, `rd_err = 1`.
- **Wrap:** 5 writes, 5 reads, then 6 writes → `tail` wraps, with `reg_we` sequence `0x20`, `0x40`, `0x80`, `0x01`, `0x02`, `0x04`; `data_count = 6`.
- **Simultaneous requests:**
  - From `count = 3`: `rd_en = wr_en = 1` for 4 cycles → count stays 3 and both acks are set each cycle.
  - At empty: both requested → write accepted, `rd_err = 1`, `data_count = 1`.
  - At full: both requested → read accepted, `wr_err = 1`, `data_count = 7`.
- **Reset mid-stream:** assert `reset_n = 0` between clock edges at `count = 5` → outputs return to reset values immediately; the subsequent write targets `reg_we = 0x01`.
